booth_mac_accumulator: RTL and testbench
========================================

BOOTH_MAC_ACCUMULATOR -- requirements
Module: booth_mac_accumulator

Interface
REQ-001 The module SHALL have a parameter ACC_W, default 24, giving the signed accumulator and sum width (legal range 17..32).
REQ-002 The module SHALL have a parameter PROD_W, default 16, giving the signed product input width.
REQ-003 The module SHALL have port clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The module SHALL have port product_in  input  PROD_W  signed product from the upstream Booth multiplier.
REQ-006 The module SHALL have port done_in  input  1  upstream level done flag; product_in is valid while high.
REQ-007 The module SHALL have port acc_len  input  4  number of products per sum; 0 means 16.
REQ-008 The module SHALL have port clear  input  1  synchronous flush of the accumulator, counter and flags.
REQ-009 The module SHALL have port sum_out  output  ACC_W  signed completed group sum.
REQ-010 The module SHALL have port sum_sat  output  1  high if saturation occurred within the group held in sum_out.
REQ-011 The module SHALL have port sum_valid  output  1  sum_out/sum_sat hold a completed group.
REQ-012 The module SHALL have port sum_ready  input  1  consumer accepts the sum when sum_valid && sum_ready.
REQ-013 The module SHALL have port busy  output  1  a group is partially accumulated (count != 0).
REQ-014 The module SHALL have port lost  output  1  sticky flag: a completed group was dropped.

Function
REQ-015 The module SHALL register done_in into done_q and define take = done_in && !done_q; only take SHALL consume product_in.
REQ-016 A level-high done_in lasting many cycles SHALL count as exactly one product.
REQ-017 The module SHALL sign-extend product_in to ACC_W before adding.
REQ-018 On take with count == 0, the module SHALL latch len = (acc_len == 0 ? 16 : acc_len), set acc = ext(product_in), clear grp_sat and set count = 1.
REQ-019 acc_len changes mid-group SHALL NOT affect the group in progress.
REQ-020 On take with count != 0, the module SHALL set acc = sat(acc + ext(product_in)) and increment count.
REQ-021 sat() SHALL clamp to the most positive or most negative ACC_W value on signed overflow and SHALL set grp_sat.
REQ-022 When the take being processed brings count to len, the module SHALL complete the group at that same edge, with zero added latency.
REQ-023 On completion, sum_out SHALL receive the final sum including that product, sum_sat SHALL receive the final grp_sat, and count SHALL return to 0.
REQ-024 A completion SHALL set sum_valid = 1 if the output slot is free or is being accepted (sum_valid && sum_ready) in the same cycle.
REQ-025 A completion SHALL NOT overwrite sum_out while sum_valid && !sum_ready; the new group SHALL be discarded and lost set to 1.
REQ-026 Without a completion, sum_valid && sum_ready SHALL clear sum_valid at the next edge.
REQ-027 sum_out and sum_sat SHALL be stable while sum_valid && !sum_ready.
REQ-028 Accumulation SHALL continue independently of output back-pressure; the output register forms a one-entry double buffer.
REQ-029 clear SHALL take priority over take and over sum acceptance.
REQ-030 clear SHALL set acc, count and grp_sat to 0 and sum_valid, sum_sat and lost to 0; sum_out SHALL keep its value.
REQ-031 busy SHALL equal (count != 0), registered.

Reset
REQ-032 While rst is high, sum_out = 0, sum_sat = 0, sum_valid = 0, busy = 0 and lost = 0, with acc = 0, count = 0, grp_sat = 0 and done_q = 1.
REQ-033 done_q resetting to 1 SHALL prevent a done_in already high at reset release from being counted.
REQ-034 Reset asserted mid-group SHALL discard the partial group, and no sum SHALL be emitted for it.

Verification
REQ-035 Test: acc_len=4; products 3, -5, 100, 2, each given as a done_in 0->1 edge held 3 cycles; sum_ready=1 -> one sum_valid pulse with sum_out=100, sum_sat=0, coinciding with the edge after the 4th done rise.
REQ-036 Test: acc_len=0; 16 products of 0x7FFF -> sum_out=524272 (0x07FFF0), sum_sat=0.
REQ-037 Test: ACC_W=17, acc_len=3, products 0x7FFF x3 -> sum_out=65535, sum_sat=1; next group of 1, 1 -> sum_sat=0.
REQ-038 Test: acc_len=1, sum_ready=0; products 7, then 9 -> sum_out stays 7, lost=1; raise sum_ready -> sum_valid drops after one cycle.
REQ-039 Test: acc_len=2, sum_valid high with sum_ready=1 in the same cycle as the completing take -> sum_valid stays 1, sum_out updates, lost=0.
REQ-040 Test: reset asserted after 2 of 4 products, with done_in held high across release -> no sum emitted, busy=0; next 4 fresh edges yield a correct sum.

Source files
------------

// File: rtl/booth_mac_accumulator.sv
// Accumulates groups of signed Booth products (one per done_in rising edge) with
// saturation, and hands completed sums to a one-entry valid/ready output register.
module booth_mac_accumulator #(
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned PROD_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [PROD_W-1:0] product_in,
    input  logic                     done_in,
    input  logic [3:0]               acc_len,
    input  logic                     clear,
    output logic signed [ACC_W-1:0]  sum_out,
    output logic                     sum_sat,
    output logic                     sum_valid,
    input  logic                     sum_ready,
    output logic                     busy,
    output logic                     lost
);

    localparam int unsigned CNT_W = 5;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic                    done_q, done_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic                    grp_sat_q, grp_sat_d;
    logic signed [ACC_W-1:0] sum_out_q, sum_out_d;
    logic                    sum_sat_q, sum_sat_d;
    logic                    sum_valid_q, sum_valid_d;
    logic                    lost_q, lost_d;
    logic                    busy_q, busy_d;

    logic                    take;
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W:0]   wide;
    logic                    ovf;
    logic [CNT_W-1:0]        len_eff;
    logic signed [ACC_W-1:0] acc_new;
    logic                    sat_new;
    logic [CNT_W-1:0]        cnt_new;
    logic                    complete;

    // Datapath and next-state logic for the group accumulator and output slot.
    always_comb begin
        done_d      = done_in;
        acc_d       = acc_q;
        count_d     = count_q;
        len_d       = len_q;
        grp_sat_d   = grp_sat_q;
        sum_out_d   = sum_out_q;
        sum_sat_d   = sum_sat_q;
        sum_valid_d = sum_valid_q;
        lost_d      = lost_q;
        complete    = 1'b0;

        take = done_in && !done_q;
        ext  = ACC_W'(product_in);
        wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(ext);
        ovf  = wide[ACC_W] ^ wide[ACC_W-1];

        // First product of a group latches the length and seeds the accumulator.
        if (count_q == '0) begin
            len_eff = (acc_len == 4'd0) ? CNT_W'(16) : CNT_W'(acc_len);
            acc_new = ext;
            sat_new = 1'b0;
            cnt_new = CNT_W'(1);
        end else begin
            len_eff = len_q;
            acc_new = ovf ? (wide[ACC_W] ? ACC_MIN : ACC_MAX) : wide[ACC_W-1:0];
            sat_new = grp_sat_q | ovf;
            cnt_new = count_q + CNT_W'(1);
        end

        if (clear) begin
            acc_d       = '0;
            count_d     = '0;
            grp_sat_d   = 1'b0;
            sum_valid_d = 1'b0;
            sum_sat_d   = 1'b0;
            lost_d      = 1'b0;
        end else begin
            if (take) begin
                len_d = len_eff;
                if (cnt_new == len_eff) begin
                    complete  = 1'b1;
                    acc_d     = '0;
                    count_d   = '0;
                    grp_sat_d = 1'b0;
                end else begin
                    acc_d     = acc_new;
                    count_d   = cnt_new;
                    grp_sat_d = sat_new;
                end
            end
            // Output slot: load when free or draining this cycle, else drop the group.
            if (complete) begin
                if (!sum_valid_q || sum_ready) begin
                    sum_out_d   = acc_new;
                    sum_sat_d   = sat_new;
                    sum_valid_d = 1'b1;
                end else begin
                    lost_d = 1'b1;
                end
            end else if (sum_valid_q && sum_ready) begin
                sum_valid_d = 1'b0;
            end
        end

        busy_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q      <= 1'b1;
            acc_q       <= '0;
            count_q     <= '0;
            len_q       <= '0;
            grp_sat_q   <= 1'b0;
            sum_out_q   <= '0;
            sum_sat_q   <= 1'b0;
            sum_valid_q <= 1'b0;
            lost_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            done_q      <= done_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            len_q       <= len_d;
            grp_sat_q   <= grp_sat_d;
            sum_out_q   <= sum_out_d;
            sum_sat_q   <= sum_sat_d;
            sum_valid_q <= sum_valid_d;
            lost_q      <= lost_d;
            busy_q      <= busy_d;
        end
    end

    assign sum_out   = sum_out_q;
    assign sum_sat   = sum_sat_q;
    assign sum_valid = sum_valid_q;
    assign busy      = busy_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Bench for booth_mac_accumulator: a 24-bit and a 17-bit instance share stimulus and
// are compared every cycle against a group-list reference model.
module tb_booth_mac_accumulator;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] prod;
    logic               done;
    logic [3:0]         acc_len;
    logic               clear;
    logic               rdy;

    logic signed [23:0] sum_a;
    logic               sat_a, valid_a, busy_a, lost_a;
    logic signed [16:0] sum_b;
    logic               sat_b, valid_b, busy_b, lost_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: products of the open group plus per-width output slot.
    int     grp[$];
    int     glen;
    bit     m_done_q;
    longint m_sum   [2];
    bit     m_sat   [2];
    bit     m_valid [2];
    bit     m_lost  [2];
    bit     m_busy;

    always #5 clk = ~clk;

    booth_mac_accumulator #(.ACC_W(24), .PROD_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .product_in(prod), .done_in(done), .acc_len(acc_len),
        .clear(clear), .sum_out(sum_a), .sum_sat(sat_a), .sum_valid(valid_a),
        .sum_ready(rdy), .busy(busy_a), .lost(lost_a)
    );

    booth_mac_accumulator #(.ACC_W(17), .PROD_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .product_in(prod), .done_in(done), .acc_len(acc_len),
        .clear(clear), .sum_out(sum_b), .sum_sat(sat_b), .sum_valid(valid_b),
        .sum_ready(rdy), .busy(busy_b), .lost(lost_b)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Running saturating sum of the completed group for a given accumulator width.
    task automatic group_sum(input int w, output longint s, output bit st);
        longint mx = (longint'(1) <<< (w - 1)) - 1;
        longint mn = -(longint'(1) <<< (w - 1));
        s  = 0;
        st = 1'b0;
        foreach (grp[i]) begin
            s = s + grp[i];
            if (s > mx) begin s = mx; st = 1'b1; end
            if (s < mn) begin s = mn; st = 1'b1; end
        end
    endtask

    task automatic model_step();
        bit     take;
        bit     complete;
        longint s;
        bit     st;
        if (rst) begin
            m_done_q = 1'b1;
            grp.delete();
            for (int k = 0; k < 2; k++) begin
                m_sum[k] = 0; m_sat[k] = 0; m_valid[k] = 0; m_lost[k] = 0;
            end
        end else begin
            take     = done && !m_done_q;
            m_done_q = done;
            if (clear) begin
                grp.delete();
                for (int k = 0; k < 2; k++) begin
                    m_sat[k] = 0; m_valid[k] = 0; m_lost[k] = 0;
                end
            end else begin
                complete = 1'b0;
                if (take) begin
                    if (grp.size() == 0) glen = (acc_len == 0) ? 16 : int'(acc_len);
                    grp.push_back(int'(prod));
                    if (grp.size() == glen) complete = 1'b1;
                end
                for (int k = 0; k < 2; k++) begin
                    if (complete) begin
                        group_sum((k == 0) ? 24 : 17, s, st);
                        if (!m_valid[k] || rdy) begin
                            m_sum[k] = s; m_sat[k] = st; m_valid[k] = 1'b1;
                        end else begin
                            m_lost[k] = 1'b1;
                        end
                    end else if (m_valid[k] && rdy) begin
                        m_valid[k] = 1'b0;
                    end
                end
                if (complete) grp.delete();
            end
        end
        m_busy = (grp.size() != 0);
    endtask

    // One clock: advance the model with the current inputs, then compare after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_eq("sum_a",   longint'(sum_a), m_sum[0]);
        check_eq("sat_a",   longint'(sat_a), longint'(m_sat[0]));
        check_eq("valid_a", longint'(valid_a), longint'(m_valid[0]));
        check_eq("lost_a",  longint'(lost_a), longint'(m_lost[0]));
        check_eq("busy_a",  longint'(busy_a), longint'(m_busy));
        check_eq("sum_b",   longint'(sum_b), m_sum[1]);
        check_eq("sat_b",   longint'(sat_b), longint'(m_sat[1]));
        check_eq("valid_b", longint'(valid_b), longint'(m_valid[1]));
        check_eq("lost_b",  longint'(lost_b), longint'(m_lost[1]));
        check_eq("busy_b",  longint'(busy_b), longint'(m_busy));
    endtask

    task automatic push(input int p, input int hold);
        prod = 16'(p);
        done = 1'b1;
        for (int i = 0; i < hold; i++) cycle();
        done = 1'b0;
        cycle();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; prod = '0; done = 1'b0; acc_len = 4'd4; clear = 1'b0; rdy = 1'b1;
        cycle();
        check_eq("reset_sum", longint'(sum_a), 0);
        check_eq("reset_busy", longint'(busy_a), 0);
        rst = 1'b0;
        cycle();

        // Group of four held-level products.
        acc_len = 4'd4;
        push(3, 3); push(-5, 3); push(100, 3);
        prod = 16'd2; done = 1'b1;
        cycle();
        check_eq("g4_valid", longint'(valid_a), 1);
        check_eq("g4_sum", longint'(sum_a), 100);
        check_eq("g4_sat", longint'(sat_a), 0);
        cycle(); cycle();
        done = 1'b0;
        cycle();

        // Length 0 means 16: max positive products, saturating only at 17 bits.
        acc_len = 4'd0;
        for (int i = 0; i < 16; i++) push(32'h7FFF, 1);
        check_eq("g16_sum_a", longint'(sum_a), 524272);
        check_eq("g16_sat_a", longint'(sat_a), 0);
        check_eq("g16_sat_b", longint'(sat_b), 1);

        acc_len = 4'd3;
        for (int i = 0; i < 3; i++) push(32'h7FFF, 1);
        check_eq("g3_sum_b", longint'(sum_b), 65535);
        check_eq("g3_sat_b", longint'(sat_b), 1);
        acc_len = 4'd2;
        push(1, 1); push(1, 1);
        check_eq("g2_sum_b", longint'(sum_b), 2);
        check_eq("g2_sat_b", longint'(sat_b), 0);

        // Back-pressure drops a group and raises lost.
        acc_len = 4'd1; rdy = 1'b0;
        push(7, 2); push(9, 2);
        check_eq("bp_sum", longint'(sum_a), 7);
        check_eq("bp_lost", longint'(lost_a), 1);
        rdy = 1'b1;
        cycle();
        check_eq("bp_drain", longint'(valid_a), 0);
        do_clear();
        check_eq("clr_lost", longint'(lost_a), 0);

        // Completion in the same cycle the held sum is accepted.
        acc_len = 4'd2; rdy = 1'b0;
        push(1, 1); push(2, 1);
        push(4, 1);
        rdy = 1'b1; prod = 16'd5; done = 1'b1;
        cycle();
        check_eq("same_valid", longint'(valid_a), 1);
        check_eq("same_sum", longint'(sum_a), 9);
        check_eq("same_lost", longint'(lost_a), 0);
        done = 1'b0;
        cycle();

        // Reset mid-group with done_in held high across release.
        acc_len = 4'd4;
        push(11, 1); push(22, 1);
        prod = 16'd33; done = 1'b1;
        rst = 1'b1; cycle(); cycle();
        rst = 1'b0; cycle(); cycle(); cycle();
        check_eq("rst_busy", longint'(busy_a), 0);
        check_eq("rst_valid", longint'(valid_a), 0);
        done = 1'b0; cycle();
        push(10, 1); push(-20, 1); push(30, 1); push(40, 1);
        check_eq("rst_next_sum", longint'(sum_a), 60);

        // Randomized traffic, biased toward large magnitudes to hit saturation.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       prod = 16'sh7FFF;
                1:       prod = -16'sh8000;
                default: prod = 16'($urandom);
            endcase
            done    = ($urandom_range(0, 2) != 0) ? ~done : done;
            acc_len = 4'($urandom_range(0, 15));
            rdy     = ($urandom_range(0, 3) != 0);
            clear   = ($urandom_range(0, 80) == 0);
            rst     = ($urandom_range(0, 300) == 0);
            cycle();
        end
        rst = 1'b0; clear = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
